cga_vram_arb: RTL and testbench

- Parametrised successor to the 16KB CGA video RAM, for larger graphics modes.
- Models one single-ported RAM of 2^ADDR_W words by DATA_W bits. The ISA bus and the CRTC pixel fetcher share it, with one RAM access per clock.
- ISA writes are posted into a write buffer of WBUF_DEPTH entries. ISA reads and full-buffer writes are stalled through a ready handshake.
- Pixel fetch always wins arbitration, so display timing is never disturbed.

---
 rtl/cga_vram_arb.sv | 208 ++++++++++++++++++++
 tb/tb_cga_vram_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_arb.sv
// Purpose: shared single-port video RAM; pixel fetch always wins, ISA writes are posted.
// Latency: pixel read 1 cycle; ISA write 0 cycles (posted); ISA read >= 2 cycles.
// Backpressure: isa_ready low while the write buffer is full or a read is still pending.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   isa_addr/isa_din/isa_dout    ISA address, write data, registered read data
//   isa_read/isa_write           level requests held until isa_ready
//   isa_op_enable                qualifies isa_read/isa_write
//   isa_ready                    current ISA request completes this cycle
//   pixel_addr/pixel_read        fetch address and strobe
//   pixel_data                   fetched data, registered, held while idle
//   wbuf_level                   number of posted writes not yet in RAM

// Purpose: generic synchronous FIFO, power-of-2 depth.
// Latency: pushed entry visible at pop side the cycle after the push.
// Backpressure: push_rdy low when full; a pop in the same cycle does not free a slot early.
module cga_vram_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_vld,
    output logic                         push_rdy,
    input  logic [WIDTH-1:0]             push_dat,
    output logic                         pop_vld,
    input  logic                         pop_rdy,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push_fire;
    logic             pop_fire;

    assign push_rdy  = (count != LVL_W'(DEPTH));
    assign pop_vld   = (count != '0);
    assign push_fire = push_vld & push_rdy;
    assign pop_fire  = pop_vld & pop_rdy;
    assign pop_dat   = mem[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module cga_vram_arb #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int BUS_ADDR_W = 19,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [BUS_ADDR_W-1:0]             isa_addr,
    input  logic [DATA_W-1:0]                 isa_din,
    output logic [DATA_W-1:0]                 isa_dout,
    input  logic                              isa_read,
    input  logic                              isa_write,
    input  logic                              isa_op_enable,
    output logic                              isa_ready,
    input  logic [BUS_ADDR_W-1:0]             pixel_addr,
    input  logic                              pixel_read,
    output logic [DATA_W-1:0]                 pixel_data,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_level
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_PEND  = 2'd1,
        RD_DONE  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_latch;
    logic              isa_ram_rd;

    logic              wr_req;
    logic              rd_req;
    logic              wbuf_push_rdy;
    logic              wbuf_pop_vld;
    logic              drain;
    wr_ent_t           wbuf_push_dat;
    wr_ent_t           wbuf_pop_dat;

    logic [DATA_W-1:0] ram [1<<ADDR_W];

    // Upper bus address bits alias away; keep them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{isa_addr[BUS_ADDR_W-1:ADDR_W], pixel_addr[BUS_ADDR_W-1:ADDR_W]};

    // A simultaneous write wins; the read is only seen without a write.
    assign wr_req = isa_op_enable & isa_write;
    assign rd_req = isa_op_enable & isa_read & ~isa_write;

    assign wbuf_push_dat.addr = isa_addr[ADDR_W-1:0];
    assign wbuf_push_dat.data = isa_din;

    cga_vram_fifo #(
        .WIDTH ($bits(wr_ent_t)),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk      (clk),
        .rst_n    (reset_n),
        .push_vld (wr_req),
        .push_rdy (wbuf_push_rdy),
        .push_dat (wbuf_push_dat),
        .pop_vld  (wbuf_pop_vld),
        .pop_rdy  (drain),
        .pop_dat  (wbuf_pop_dat),
        .level    (wbuf_level)
    );

    // Drain only when the pixel port leaves the RAM free. An ISA read
    // needs an empty buffer, so it can never collide with a drain.
    assign drain = wbuf_pop_vld & ~pixel_read;

    // Reset is folded in so a write held across reset is never acknowledged.
    assign isa_ready = reset_n & ((wr_req & wbuf_push_rdy) | (state_q == RD_DONE));

    always_comb begin
        state_d    = state_q;
        rd_latch   = 1'b0;
        isa_ram_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    rd_latch = 1'b1;
                    state_d  = RD_PEND;
                end
            end
            RD_PEND: begin
                // Waiting for an empty buffer orders the read after every earlier write.
                if (!wbuf_pop_vld && !pixel_read) begin
                    isa_ram_rd = 1'b1;
                    state_d    = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = isa_read ? WAIT_REL : IDLE;
            end
            WAIT_REL: begin
                if (!isa_read) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (rd_latch) rd_addr_q <= isa_addr[ADDR_W-1:0];
        end
    end

    // RAM array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (drain) begin
            ram[wbuf_pop_dat.addr] <= wbuf_pop_dat.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_data <= '0;
            isa_dout   <= '0;
        end else begin
            if (pixel_read) pixel_data <= ram[pixel_addr[ADDR_W-1:0]];
            if (isa_ram_rd) isa_dout   <= ram[rd_addr_q];
        end
    end
endmodule

// File: tb/tb_cga_vram_arb.sv
// Purpose: scoreboard bench for cga_vram_arb with directed vectors.
// Latency: reads/pixel fetches checked by a negedge monitor against queued expectations.
// Backpressure: every wait on isa_ready is bounded; expiry counts as a failure.
module tb_cga_vram_arb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [18:0] isa_addr;
    logic [7:0]  isa_din;
    logic [7:0]  isa_dout;
    logic        isa_read;
    logic        isa_write;
    logic        isa_op_enable;
    logic        isa_ready;
    logic [18:0] pixel_addr;
    logic        pixel_read;
    logic [7:0]  pixel_data;
    logic [2:0]  wbuf_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rd_q[$];
    logic [7:0] pix_q[$];
    logic [7:0] pix_exp = 8'h00;
    logic       pix_fired = 1'b0;

    always #5 clk = ~clk;

    cga_vram_arb #(
        .ADDR_W     (14),
        .DATA_W     (8),
        .BUS_ADDR_W (19),
        .WBUF_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .isa_addr      (isa_addr),
        .isa_din       (isa_din),
        .isa_dout      (isa_dout),
        .isa_read      (isa_read),
        .isa_write     (isa_write),
        .isa_op_enable (isa_op_enable),
        .isa_ready     (isa_ready),
        .pixel_addr    (pixel_addr),
        .pixel_read    (pixel_read),
        .pixel_data    (pixel_data),
        .wbuf_level    (wbuf_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: isa_ready never rose, expected within 50 cycles", name);
    endtask

    // Every posedge with a strobe records the expected fetch for the monitor.
    always @(posedge clk) begin
        pix_fired <= 1'b0;
        if (pixel_read && reset_n) begin
            pix_q.push_back(pix_exp);
            pix_fired <= 1'b1;
        end
    end

    // Monitor: compares outputs whenever the DUT presents them.
    always @(negedge clk) begin
        if (pix_fired) begin
            if (pix_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pixel_data: got 0x%0h with no expected entry", pixel_data);
            end else begin
                chk("pixel_data", {24'h0, pixel_data}, {24'h0, pix_q.pop_front()});
            end
        end
        if (isa_ready && isa_read && !isa_write) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL isa_dout: got 0x%0h with no expected entry", isa_dout);
            end else begin
                chk("isa_dout", {24'h0, isa_dout}, {24'h0, rd_q.pop_front()});
            end
        end
    end

    task automatic isa_wr(input logic [18:0] a, input logic [7:0] d, output int lat);
        isa_addr = a; isa_din = d; isa_write = 1'b1; isa_op_enable = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!isa_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 50) timeout_fail("isa_wr_timeout");
        @(posedge clk); #1;
        isa_write = 1'b0;
    endtask

    task automatic isa_rd(input logic [18:0] a, input logic [7:0] exp, output int lat);
        rd_q.push_back(exp);
        isa_addr = a; isa_read = 1'b1; isa_op_enable = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!isa_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 50) timeout_fail("isa_rd_timeout");
        @(posedge clk); #1;
        isa_read = 1'b0;
        @(posedge clk); #1;   // low gap so the FSM leaves WAIT_REL
    endtask

    task automatic pix(input logic [18:0] a, input logic [7:0] exp);
        pixel_addr = a; pix_exp = exp; pixel_read = 1'b1;
        @(posedge clk); #1;
        pixel_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        int lat;
        int t;
        reset_n = 1'b0; isa_addr = '0; isa_din = '0; isa_read = 1'b0;
        isa_write = 1'b0; isa_op_enable = 1'b0; pixel_addr = '0; pixel_read = 1'b0;
        #12;
        chk("rst_isa_dout", {24'h0, isa_dout}, 32'h0);
        chk("rst_pixel_data", {24'h0, pixel_data}, 32'h0);
        chk("rst_wbuf_level", {29'h0, wbuf_level}, 32'h0);
        chk("rst_isa_ready", {31'h0, isa_ready}, 32'h0);
        @(negedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read-back
        isa_wr(19'h00123, 8'hA5, lat);
        chk("wr_ready_lat", lat, 0);
        isa_rd(19'h00123, 8'hA5, lat);
        chk("rd_lat_min", lat, 2);

        // Aliasing: 0x44123 maps to 0x0123
        isa_wr(19'h44123, 8'h5A, lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("alias_drained", {29'h0, wbuf_level}, 32'h0);
        pix(19'h00123, 8'h5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pixel_hold", {24'h0, pixel_data}, 32'h5A);
        chk("isa_dout_hold", {24'h0, isa_dout}, 32'hA5);

        // Full buffer under continuous pixel fetch
        pixel_addr = 19'h00123; pix_exp = 8'h5A; pixel_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            isa_wr(19'h00300 + 19'(i), 8'h11 + 8'(i), lat);
            chk("fill_wr_lat", lat, 0);
        end
        chk("full_level", {29'h0, wbuf_level}, 32'd4);
        isa_addr = 19'h00304; isa_din = 8'h15; isa_write = 1'b1;
        @(negedge clk);
        chk("full_ready", {31'h0, isa_ready}, 32'h0);
        chk("full_level_hold", {29'h0, wbuf_level}, 32'd4);
        @(posedge clk); #1;
        pixel_read = 1'b0;
        @(negedge clk);
        chk("full_drain_cycle_ready", {31'h0, isa_ready}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_drain_ready", {31'h0, isa_ready}, 32'h1);
        chk("after_drain_level", {29'h0, wbuf_level}, 32'd3);
        @(posedge clk); #1;
        isa_write = 1'b0;
        @(negedge clk);
        chk("push_pop_level", {29'h0, wbuf_level}, 32'd3);
        t = 0;
        while (wbuf_level != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("full_drained", {29'h0, wbuf_level}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            isa_rd(19'h00300 + 19'(i), 8'h11 + 8'(i), lat);
            chk("full_rd_lat", lat, 2);
        end

        // Ordering: last of three writes to the same address wins
        isa_wr(19'h00010, 8'h01, lat);
        isa_wr(19'h00010, 8'h02, lat);
        isa_wr(19'h00010, 8'h03, lat);
        isa_rd(19'h00010, 8'h03, lat);
        chk("order_level", {29'h0, wbuf_level}, 32'h0);

        // Contention: pixel strobe toggles every cycle during a pending read
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    pixel_read = (i % 2 == 1);
                    pixel_addr = (i % 4 == 1) ? 19'h00123 : 19'h00300;
                    pix_exp    = (i % 4 == 1) ? 8'h5A : 8'h11;
                    @(posedge clk); #1;
                end
                pixel_read = 1'b0;
            end
            isa_rd(19'h00301, 8'h12, lat);
        join
        chk("contention_rd_lat", lat, 3);

        // Async reset mid-RD_PEND with two writes buffered
        pixel_addr = 19'h00123; pix_exp = 8'h5A; pixel_read = 1'b1;
        isa_wr(19'h00300, 8'hEE, lat);
        isa_wr(19'h00301, 8'hEF, lat);
        chk("pre_reset_level", {29'h0, wbuf_level}, 32'd2);
        isa_addr = 19'h00302; isa_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        pixel_read = 1'b0; isa_read = 1'b0; reset_n = 1'b0;
        #1;
        chk("arst_isa_dout", {24'h0, isa_dout}, 32'h0);
        chk("arst_pixel_data", {24'h0, pixel_data}, 32'h0);
        chk("arst_wbuf_level", {29'h0, wbuf_level}, 32'h0);
        chk("arst_isa_ready", {31'h0, isa_ready}, 32'h0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_level", {29'h0, wbuf_level}, 32'h0);
        isa_rd(19'h00300, 8'h11, lat);
        isa_rd(19'h00301, 8'h12, lat);

        @(posedge clk); #1;
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("pix_queue_empty", pix_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
